bw_io_cmos2_sio: RTL and testbench



---
 rtl/bw_io_cmos2_sio_pkg.sv | 23 ++
 rtl/bw_io_cmos2_sio_sync.sv | 27 ++
 rtl/bw_io_cmos2_sio.sv | 148 ++++++++++++++
 tb/tb_bw_io_cmos2_sio.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bw_io_cmos2_sio_pkg.sv
// Shared constants for the CMOS2 single-wire serial engine: FSM encoding and frame layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bw_io_cmos2_sio_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 3'd0,
    S_TX_BIT   = 3'd1,
    S_TURN     = 3'd2,
    S_RX_START = 3'd3,
    S_RX_BIT   = 3'd4,
    S_RX_STOP  = 3'd5
  } state_e;

  // Line idles low through the pad pull-down, so a frame opens with a high bit
  // and closes by returning the line to its idle level.
  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/bw_io_cmos2_sio_sync.sv
// Two-flop synchronizer for the asynchronous pad receiver output.
// Latency: 2 clk; no backpressure.
// Ports: clk/arst_l clock and async active-low reset (outputs reset to 0), d_i async input, q_o synchronized output.
module bw_io_cmos2_sio_sync (
  input  logic clk,
  input  logic arst_l,
  input  logic d_i,
  output logic q_o
);
  import bw_io_cmos2_sio_pkg::*;

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bw_io_cmos2_sio.sv
// Half-duplex single-wire serial engine driving a pull-down-terminated CMOS2 pad (10-bit frames, DIV clk/bit).
// Latency: TX frame 10*DIV clk plus TURN guard; RX rx_vld one clk after the stop sample.
// Backpressure: tx_rdy only in IDLE with the line low; an incoming start bit wins over tx_vld.
// Ports: clk/arst_l; tx_vld/tx_data/tx_rdy transmit handshake; rx_vld/rx_data/rx_err receive result;
//        pad_oe/pad_data to the pad, pad_to_core from the pad receiver (asynchronous).
module bw_io_cmos2_sio #(
  parameter int DIV  = 16,  // clocks per bit, even, >= 4
  parameter int TURN = 4    // receive guard after releasing oe, 1..DIV
) (
  input  logic       clk,
  input  logic       arst_l,
  input  logic       tx_vld,
  input  logic [7:0] tx_data,
  output logic       tx_rdy,
  output logic       rx_vld,
  output logic [7:0] rx_data,
  output logic       rx_err,
  output logic       pad_oe,
  output logic       pad_data,
  input  logic       pad_to_core
);
  import bw_io_cmos2_sio_pkg::*;

  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] HALF_LAST = DW'(DIV / 2 - 1);
  // The guard is timed on the bit divider, so TURN must not exceed DIV.
  localparam logic [DW-1:0] TURN_LAST = DW'(TURN - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);
  localparam logic [3:0]    LAST_DATA = 4'd7;

  state_e      state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        rx_vld_q, rx_vld_d;
  logic        rx_err_q, rx_err_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_s;
  logic [9:0]  tx_frame;

  bw_io_cmos2_sio_sync u_sync (
    .clk    (clk),
    .arst_l (arst_l),
    .d_i    (pad_to_core),
    .q_o    (rx_s)
  );

  assign tx_frame = {STOP_BIT, sh_q, START_BIT};
  assign tx_rdy   = (state_q == S_IDLE) && !rx_s;
  // Decoded straight from the state register so reset releases the pad without waiting for a clock.
  assign pad_oe   = (state_q == S_TX_BIT);
  assign pad_data = pad_oe & tx_frame[bit_q];
  assign rx_vld   = rx_vld_q;
  assign rx_err   = rx_err_q;
  assign rx_data  = rx_data_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    rx_vld_d  = 1'b0;
    rx_err_d  = rx_err_q;
    rx_data_d = rx_data_q;

    case (state_q)
      S_IDLE: begin
        if (tx_vld && tx_rdy) begin
          sh_d    = tx_data;
          state_d = S_TX_BIT;
        end else if (rx_s) begin
          state_d = S_RX_START;
        end
      end
      S_TX_BIT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == LAST_BIT) state_d = S_TURN;
          else                   bit_d   = bit_q + 4'd1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_TURN: begin
        // Our own echo is still on the line here; rx_s is deliberately not looked at.
        if (div_q == TURN_LAST) state_d = S_IDLE;
        else                    div_d   = div_q + DW'(1);
      end
      S_RX_START: begin
        if (div_q == HALF_LAST) state_d = rx_s ? S_RX_BIT : S_IDLE;
        else                    div_d   = div_q + DW'(1);
      end
      S_RX_BIT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          if (bit_q == LAST_DATA) state_d = S_RX_STOP;
          else                    bit_d   = bit_q + 4'd1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_RX_STOP: begin
        // bit_q==0: waiting for the stop sample; bit_q!=0: stop was high, wait for the line to
        // drop so the stuck-high level is not taken as a new start bit.
        if (bit_q != 4'd0) begin
          if (!rx_s) state_d = S_IDLE;
        end else if (div_q == DIV_LAST) begin
          rx_vld_d  = 1'b1;
          rx_data_d = sh_q;
          rx_err_d  = rx_s;
          if (rx_s) bit_d   = 4'd1;
          else      state_d = S_IDLE;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      div_d = '0;
      bit_d = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      rx_vld_q  <= 1'b0;
      rx_err_q  <= 1'b0;
      rx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      rx_vld_q  <= rx_vld_d;
      rx_err_q  <= rx_err_d;
      rx_data_q <= rx_data_d;
    end
  end

endmodule

// File: tb/tb_bw_io_cmos2_sio.sv
// Bench for bw_io_cmos2_sio: behavioural pad (pull-down, to_core = pad), expected frames queued at stimulus,
// independent TX and RX monitors pop and compare when the DUT presents a frame or an rx_vld pulse.
module tb_bw_io_cmos2_sio;
  localparam int DIV  = 16;
  localparam int TURN = 4;
  localparam int HALF = DIV / 2;

  logic       clk      = 1'b0;
  logic       arst_l   = 1'b0;
  logic       tx_vld   = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       line_drv = 1'b0;
  logic       tx_rdy, rx_vld, rx_err, pad_oe, pad_data, pad_to_core;
  logic [7:0] rx_data;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [7:0] d; logic e; int at; } rx_exp_t;
  typedef struct { logic [7:0] d; int at; bit abort; } tx_exp_t;
  rx_exp_t rx_q[$];
  tx_exp_t tx_q[$];

  // Pad: driven by the engine when oe, otherwise whatever the far end drives (0 = pull-down).
  assign pad_to_core = pad_oe ? pad_data : line_drv;

  bw_io_cmos2_sio #(.DIV(DIV), .TURN(TURN)) dut (
    .clk         (clk),
    .arst_l      (arst_l),
    .tx_vld      (tx_vld),
    .tx_data     (tx_data),
    .tx_rdy      (tx_rdy),
    .rx_vld      (rx_vld),
    .rx_data     (rx_data),
    .rx_err      (rx_err),
    .pad_oe      (pad_oe),
    .pad_data    (pad_data),
    .pad_to_core (pad_to_core)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmit one byte; returns the cycle in which tx_vld && tx_rdy held.
  task automatic send_tx(input logic [7:0] d, output int n);
    tx_exp_t e;
    int w = 0;
    tx_vld = 1'b1;
    tx_data = d;
    while (tx_rdy !== 1'b1 && w < 4000) begin @(negedge clk); w++; end
    check("tx_rdy_wait", tx_rdy, 1);
    n = cyc;
    if (tx_rdy !== 1'b1) begin tx_vld = 1'b0; return; end
    e.d = d; e.at = n + 1; e.abort = 1'b0;
    tx_q.push_back(e);
    @(negedge clk);
    tx_vld = 1'b0;
    tx_data = 8'($urandom);
    check("tx_rdy_busy", tx_rdy, 0);
    repeat (10 * DIV + TURN - 1) @(negedge clk);
    check("tx_rdy_turn", tx_rdy, 0);
    @(negedge clk);
    check("tx_rdy_back", tx_rdy, 1);
  endtask

  // Far end drives one frame starting this cycle; stop level held 'extra' more cycles.
  task automatic send_rx(input logic [7:0] d, input logic stop, input int extra);
    rx_exp_t e;
    logic [9:0] fr;
    fr = {stop, d, 1'b1};
    e.d = d; e.e = stop;
    e.at = cyc + 2 + HALF + 9 * DIV + 1;
    rx_q.push_back(e);
    for (int b = 0; b < 10; b++) begin
      line_drv = fr[b];
      repeat (DIV) @(negedge clk);
    end
    repeat (extra) @(negedge clk);
    line_drv = 1'b0;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic glitch(input int len);
    line_drv = 1'b1;
    repeat (len) @(negedge clk);
    line_drv = 1'b0;
    repeat (DIV) @(negedge clk);
    check("glitch_rdy", tx_rdy, 1);
  endtask

  task automatic tx_reset_mid(input logic [7:0] d);
    tx_exp_t e;
    int w = 0;
    tx_vld = 1'b1;
    tx_data = d;
    while (tx_rdy !== 1'b1 && w < 4000) begin @(negedge clk); w++; end
    check("rst_tx_rdy_wait", tx_rdy, 1);
    e.d = d; e.at = cyc + 1; e.abort = 1'b1;
    tx_q.push_back(e);
    @(negedge clk);
    tx_vld = 1'b0;
    repeat (4 * DIV + 3) @(negedge clk);
    check("mid_tx_oe", pad_oe, 1);
    #2 arst_l = 1'b0;
    #1;
    check("rst_async_oe", pad_oe, 0);
    check("rst_async_data", pad_data, 0);
    check("rst_async_rx_vld", rx_vld, 0);
    check("rst_async_rx_err", rx_err, 0);
    check("rst_async_rx_data", rx_data, 8'h00);
    repeat (3) @(negedge clk);
    arst_l = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rdy_after", tx_rdy, 1);
  endtask

  initial begin : rx_mon
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (rx_vld !== 1'b0) begin
        if (rx_q.size() == 0) begin
          check("rx_unexpected", rx_vld, 0);
        end else begin
          e = rx_q.pop_front();
          check("rx_data", rx_data, e.d);
          check("rx_err", rx_err, e.e);
          check("rx_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin : tx_mon
    tx_exp_t e;
    logic [9:0] fr;
    bit aborted;
    int bad;
    int t0;
    forever begin
      @(negedge clk);
      if (arst_l && pad_oe !== 1'b0) begin
        t0 = cyc; aborted = 1'b0; bad = 0;
        if (tx_q.size() == 0) begin
          check("tx_unexpected", pad_oe, 0);
          e.d = 8'h00; e.at = t0; e.abort = 1'b0;
        end else begin
          e = tx_q.pop_front();
        end
        fr = {1'b0, e.d, 1'b1};
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int c = 0; c < DIV && !aborted; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (!arst_l) aborted = 1'b1;
            else if (pad_oe !== 1'b1 || pad_data !== fr[b]) bad++;
          end
        end
        check("tx_abort", aborted, e.abort);
        if (!aborted) begin
          check("tx_start_cycle", t0, e.at);
          check("tx_bits_bad", bad, 0);
          @(negedge clk);
          check("tx_oe_fall", pad_oe, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    int k;
    int exp_acc;
    int bound;
    arst_l = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pad_oe", pad_oe, 0);
    check("rst_pad_data", pad_data, 0);
    check("rst_rx_vld", rx_vld, 0);
    check("rst_rx_err", rx_err, 0);
    check("rst_rx_data", rx_data, 8'h00);
    arst_l = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_rdy", tx_rdy, 1);

    send_tx(8'hA5, n);
    repeat (5) @(negedge clk);
    send_rx(8'h3C, 1'b0, 0);
    send_rx(8'h81, 1'b1, 40);
    glitch(5);

    // Start bit arrives in the same cycle tx_vld is raised: receive first, then transmit.
    k = cyc;
    exp_acc = k + 2 + HALF + 9 * DIV + 1;
    fork
      send_rx(8'h5A, 1'b0, 0);
      begin
        repeat (2) @(negedge clk);
        check("collide_rdy", tx_rdy, 0);
        send_tx(8'hC3, n);
      end
    join
    check("collide_accept", n, exp_acc);

    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0:       send_tx(8'($urandom), n);
        1:       send_rx(8'($urandom), 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 20)));
        default: glitch(int'($urandom_range(1, HALF)));
      endcase
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end

    tx_reset_mid(8'($urandom));
    send_tx(8'($urandom), n);
    send_rx(8'($urandom), 1'b0, 0);

    bound = 0;
    while ((rx_q.size() != 0 || tx_q.size() != 0) && bound < 2000) begin
      @(negedge clk);
      bound++;
    end
    check("rx_queue_empty", rx_q.size(), 0);
    check("tx_queue_empty", tx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
